// File: rtl/wb_byte_ram_bridge_pkg.sv
// Shared constants and state encoding for the Wishbone-to-byte-RAM bridge.
package wb_byte_ram_bridge_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 2;
    localparam int WORD_W     = BYTE_W * WORD_BYTES;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_WRITE = 3'd1;
    localparam state_t ST_READ  = 3'd2;
    localparam state_t ST_DRAIN = 3'd3;
    localparam state_t ST_ACK   = 3'd4;

endpackage

// File: rtl/wb_byte_ram_bridge.sv
// Wishbone classic slave: each 32-bit word access becomes four byte
// accesses on an 8-bit dual-port RAM with 1-cycle read latency.
module wb_byte_ram_bridge
    import wb_byte_ram_bridge_pkg::*;
#(
    parameter int aw = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [aw-3:0]     i_wb_adr,
    input  logic [WORD_W-1:0] i_wb_dat,
    input  logic [3:0]        i_wb_sel,
    input  logic              i_wb_we,
    input  logic              i_wb_stb,
    output logic [WORD_W-1:0] o_wb_rdt,
    output logic              o_wb_ack,
    output logic              o_wen,
    output logic [aw-1:0]     o_waddr,
    output logic [BYTE_W-1:0] o_wdata,
    output logic [aw-1:0]     o_raddr,
    input  logic [BYTE_W-1:0] i_rdata
);

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        r_cnt_d;
    logic                    r_cap;
    logic                    r_ack;
    logic [aw-3:0]           r_adr;
    logic [WORD_W-1:0]       r_dat;
    logic [WORD_BYTES-1:0]   r_sel;
    logic                    r_we;
    logic [WORD_W-1:0]       r_rdt;

    logic                    w_accept;
    logic [aw-1:0]           w_baddr;

    assign w_accept = (r_state == ST_IDLE) && i_wb_stb && !r_ack;
    assign w_baddr  = {r_adr, r_cnt};

    // RAM side is decoded from registers only; no path from the bus inputs
    assign o_waddr  = w_baddr;
    assign o_raddr  = w_baddr;
    assign o_wdata  = r_dat[{r_cnt, 3'b000} +: BYTE_W];
    assign o_wen    = (r_state == ST_WRITE) && r_we && r_sel[r_cnt];
    assign o_wb_ack = r_ack;
    assign o_wb_rdt = r_rdt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cnt_d <= '0;
            r_cap   <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_ack   <= 1'b0;
            // read data lags its address by one cycle
            r_cap   <= (r_state == ST_READ);
            r_cnt_d <= r_cnt;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= '0;
                        r_state <= i_wb_we ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_state <= ST_ACK;
                    end
                end
                ST_READ: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    r_ack   <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_adr <= '0;
            r_dat <= '0;
            r_sel <= '0;
            r_we  <= 1'b0;
            r_rdt <= '0;
        end else begin
            if (w_accept) begin
                r_adr <= i_wb_adr;
                r_dat <= i_wb_dat;
                r_sel <= i_wb_sel;
                r_we  <= i_wb_we;
            end
            if (r_cap) begin
                r_rdt[{r_cnt_d, 3'b000} +: BYTE_W] <= i_rdata;
            end
        end
    end

endmodule

// File: doc/wb_byte_ram_bridge.md
Name: wb_byte_ram_bridge

Overview:
Wishbone classic slave that turns 32-bit word reads and writes into sequences of byte accesses on an 8-bit dual-port RAM. The RAM has one write port, one read port and 1-cycle registered read latency. The bridge sits directly upstream of the byte RAM in the SoC memory path and gives the CPU bus a word-addressed interface with byte enables. One transaction is in flight at a time; four RAM cycles are used per word.

Parameters:
aw, 10, RAM byte-address width; word address is aw-2 bits; aw >= 3

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
i_wb_adr  in  aw-2  word address
i_wb_dat  in  32  write data, byte 0 = bits 7:0
i_wb_sel  in  4  byte enables, bit n -> byte n
i_wb_we  in  1  1 = write, 0 = read
i_wb_stb  in  1  request strobe (cyc folded in)
o_wb_rdt  out  32  read data, valid when o_wb_ack is high on a read
o_wb_ack  out  1  single-cycle transaction acknowledge
o_wen  out  1  RAM write enable
o_waddr  out  aw  RAM byte write address
o_wdata  out  8  RAM write data
o_raddr  out  aw  RAM byte read address
i_rdata  in  8  RAM read data, = mem[o_raddr] from the previous cycle

Behaviour:
- Reset (async, active-high):
  - state=IDLE, cnt=0, o_wb_ack=0, o_wen=0, o_wb_rdt=0.
  - Latched adr/dat/sel/we cleared to 0.
- RAM-side outputs are decoded from registered state only. There is no combinational path from wb inputs to RAM outputs.
- States: IDLE, WRITE, READ, DRAIN, ACK. The 2-bit byte counter is cnt.
- IDLE:
  - Accepts a request when i_wb_stb=1 and o_wb_ack=0.
  - On acceptance, latches adr/dat/sel/we and sets cnt=0.
  - Next state is WRITE if we=1, else READ.
- WRITE:
  - o_waddr={adr_q,cnt}, o_wdata=dat_q[8*cnt+:8], o_wen=sel_q[cnt].
  - cnt increments every cycle; at cnt=3, next state is ACK.
  - Unselected bytes still take a cycle. Fixed 4 cycles; sel=0000 writes nothing but is acked.
- READ:
  - o_raddr={adr_q,cnt}. cnt increments; at cnt=3, next state is DRAIN.
  - One cycle after address n is presented, i_rdata is captured into o_wb_rdt[8*n+:8] using a 1-cycle-delayed copy of cnt and a capture-valid flag.
- DRAIN: captures byte 3, then next state is ACK.
- ACK:
  - o_wb_ack=1 (registered) for exactly one cycle, then IDLE.
  - Read data is complete and stable during this cycle.
- Latency, counted from the accepting edge (edge 0):
  - Write: ack high between edges 5 and 6.
  - Read: ack high between edges 6 and 7.
- o_wb_rdt holds its last read value through writes and idle. Sel is ignored on reads; all 4 bytes are returned.
- o_wen=0 in every state except WRITE with a selected byte.
- o_raddr/o_waddr outside their active state: hold {adr_q,cnt}, don't-care for the RAM.
- The bridge never reads and writes in the same cycle, so the RAM read-during-write ordering is irrelevant.
- Master protocol:
  - The master must drop stb in the cycle after ack.
  - A stb still high in the cycle following ack starts a new transaction (back-to-back allowed).
  - Changes to adr/dat/sel/we while busy are ignored; latched values are used.
- Reset mid-transaction: immediate return to IDLE, no ack. Bytes already written stay in RAM (no rollback).
- Address wrap: {adr_q,cnt} never carries out of aw bits. Word aw-2 bits all-ones maps to the last 4 bytes.

Decomposition:
- Shared package holds:
  - state enum (IDLE, WRITE, READ, DRAIN, ACK)
  - BYTE_W=8
  - WORD_BYTES=4
  - CNT_W=2
- No sub-module: the block is a single FSM plus datapath.
- The bench instantiates the existing byte RAM with memsize=2**aw as the downstream model.

Test Plan:
- Write adr=0x005, dat=0xDEADBEEF, sel=1111 -> o_wen high 4 cycles at byte addrs 0x014..0x017 with data EF,BE,AD,DE; ack exactly 5 cycles after acceptance; RAM holds bytes.
- Read adr=0x005 after the above -> o_raddr 0x014..0x017 on consecutive cycles; ack 6 cycles after acceptance with o_wb_rdt=0xDEADBEEF.
- Write adr=0x005, dat=0x11223344, sel=0101 -> wen only at 0x014 and 0x016; subsequent read returns 0xDE22BE44; sel=0000 write acks with no wen.
- Back-to-back: stb held high across ack, write then read to adr=0x0FF (last word, aw=10) -> second transaction starts the cycle after ack; addrs 0x3FC..0x3FF, no wrap error.
- Assert reset during WRITE cycle 2 of a sel=1111 write of 0xAABBCCDD to zeroed adr=0x010 -> ack, wen, rdt go 0 at once; FSM returns to IDLE; read returns 0x0000CCDD (bytes 0-1 written); next transaction is accepted normally.
- Change i_wb_dat/adr mid-transaction -> RAM sees only the values latched at acceptance.
